wb_write_queue: RTL and testbench
=================================

Name: wb_write_queue

Overview:
- Write-back-side writer for the 32 x 64-bit register file.
- Buffers retiring write requests in a small FIFO and drains one per cycle.
- Decodes each destination register into a one-hot write-enable bus; read ports select by mux, write ports select by decoder.
- Exports a pending-write vector so hazard logic can stall readers of registers with writes still in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DATA_W, 64, register data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  queue can accept; = !full
- wr_addr  in  5  destination register number
- wr_data  in  DATA_W  write data
- rf_ready  in  1  register file can take a write this cycle
- we_onehot  out  32  registered one-hot write enable, bit r writes Xr
- we_data  out  DATA_W  registered write data, valid while we_onehot != 0
- pending  out  32  bit r set while any queued or output-stage write targets Xr
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds DEPTH entries

Behaviour:
- Reset (reset_n low at an edge): FIFO count 0, pointers 0, output stage invalid.
  - Cycle after the reset edge: we_onehot=0, we_data=0, pending=0, empty=1, full=0, wr_ready=1.
  - Any in-flight write is discarded, including one mid-drain.
- Accept: wr_valid && wr_ready at an edge.
  - wr_addr != 31: enqueue {addr,data} at the tail.
  - wr_addr == 31 (XZR): handshake completes but nothing is enqueued; count and pending are unchanged.
- No push when full. wr_ready is combinational from full only, never from rf_ready.
- Pop: at an edge with !empty && rf_ready, the head is removed and loaded into the output stage.
  - During the following cycle, we_onehot = 1<<addr and we_data = data, for exactly one cycle.
  - Otherwise the output stage is invalid and we_onehot = 0. we_data holds its last value.
- Latency: request accepted at edge t into an empty queue, rf_ready high -> popped at edge t+1 -> we_onehot high in the cycle after edge t+1, i.e. two cycles.
- Simultaneous push and pop: count unchanged, both pointers advance; legal at any count, including DEPTH-1 and 1.
- Pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- rf_ready low: no pop; the output stage goes invalid the next cycle. Entries are retained in order.
- pending: combinational OR over all valid FIFO entries plus the valid output stage.
  - Bit r is set the cycle after accept of a write to Xr.
  - Bit r is clear in the cycle after that write's we_onehot cycle, unless another write to Xr remains.
  - Bit 31 is always 0.
- Ordering: writes leave strictly in acceptance order. Two writes to the same register both appear, the later one last.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: adds ports fwd_addr (in, 5), fwd_hit (out, 1), fwd_data (out, DATA_W).
  - fwd_hit=1 and fwd_data=youngest matching entry, searched tail-to-head then the output stage, all combinational.
  - fwd_addr==31 never hits.
- Undefined: these ports and the search logic are absent; all other behaviour is identical.

Decomposition:
- Package regfile_pkg holds:
  - NREGS=32, REG_ADDR_W=5, XZR=5'd31
  - typedef reg_addr_t (logic [4:0])
  - struct wb_entry_t {reg_addr_t addr; logic [DATA_W-1:0] data;}
- Sub-module decoder5_32: combinational 5-bit to 32-bit one-hot decoder with an enable input.
  - Used for the output-stage we_onehot.
  - Also used per entry to build pending.

Test Plan:
- Reset then a single write X5=0x1234, rf_ready=1 -> we_onehot=0x00000020, we_data=0x1234 exactly two cycles after accept; pending[5]=1 until the cycle after.
- Write to X31 with data 0xFFFF -> wr_ready=1, empty stays 1, we_onehot never nonzero, pending=0.
- rf_ready=0 with four writes X1..X4 -> full=1, wr_ready=0, pending=0x1E. Then rf_ready=1 -> we_onehot sequence 0x2,0x4,0x8,0x10 on consecutive cycles.
- Writes X7=0xA then X7=0xB back-to-back -> two we cycles, 0xA then 0xB; pending[7] clears only after 0xB is written.
- Queue holding 2 entries, assert reset_n=0 for one edge -> next cycle we_onehot=0, pending=0, empty=1; the queued writes never appear.
- WB_FWD_EN build: queue X9=0x1 then X9=0x2 with rf_ready=0, fwd_addr=9 -> fwd_hit=1, fwd_data=0x2; fwd_addr=31 -> fwd_hit=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the write-back path.
package regfile_pkg;

    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RF_DATA_W  = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t XZR = 5'd31;

    typedef struct packed {
        reg_addr_t            addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/decoder5_32.sv
// Combinational 5-to-32 one-hot decoder; all-zero output when disabled.
module decoder5_32
    import regfile_pkg::*;
(
    input  reg_addr_t         addr_i,
    input  logic              en_i,
    output logic [NREGS-1:0]  onehot_o
);

    assign onehot_o = en_i ? (NREGS'(1) << addr_i) : '0;

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue: FIFO of register writes drained one per cycle into a one-hot write port.
// Optional macro WB_FWD_EN adds a combinational forwarding search (fwd_addr/fwd_hit/fwd_data).
module wb_write_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  reg_addr_t         wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rf_ready,
    output logic [NREGS-1:0]  we_onehot,
    output logic [DATA_W-1:0] we_data,
    output logic [NREGS-1:0]  pending,
`ifdef WB_FWD_EN
    input  reg_addr_t         fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    reg_addr_t         mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic              out_vld_q;
    reg_addr_t         out_addr_q;
    logic [DATA_W-1:0] out_data_q;

    logic              push, pop;
    logic [DEPTH-1:0]  ent_vld;
    logic [NREGS-1:0]  ent_oh [DEPTH];
    logic [NREGS-1:0]  out_oh;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    // XZR writes complete the handshake but never occupy a slot
    assign push     = wr_valid && !full && (wr_addr != XZR);
    assign pop      = !empty && rf_ready;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            out_vld_q <= pop;
            if (pop) begin
                out_addr_q <= mem_addr_q[rptr_q];
                out_data_q <= mem_data_q[rptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wptr_q] <= wr_addr;
            mem_data_q[wptr_q] <= wr_data;
        end
    end

    // A slot is live when its distance from the head is below the count
    always_comb begin
        logic [AW-1:0] offs;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs       = AW'(i) - rptr_q;
            ent_vld[i] = ({1'b0, offs} < count_q);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent_dec
        decoder5_32 u_ent_dec (
            .addr_i   (mem_addr_q[g]),
            .en_i     (ent_vld[g]),
            .onehot_o (ent_oh[g])
        );
    end

    decoder5_32 u_out_dec (
        .addr_i   (out_addr_q),
        .en_i     (out_vld_q),
        .onehot_o (out_oh)
    );

    assign we_onehot = out_oh;
    assign we_data   = out_data_q;

    always_comb begin
        pending = out_oh;
        for (int i = 0; i < DEPTH; i++) pending = pending | ent_oh[i];
        pending[XZR] = 1'b0;
    end

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the youngest match wins; output stage is oldest of all
    always_comb begin
        logic [AW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (out_vld_q && out_addr_q == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = out_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr_q + AW'(k);
            if (ent_vld[idx] && mem_addr_q[idx] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[idx];
            end
        end
        if (fwd_addr == XZR) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (default build, plus WB_FWD_EN checks when defined).
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rf_ready;
    logic [31:0] we_onehot;
    logic [63:0] we_data;
    logic [31:0] pending;
    logic        empty;
    logic        full;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [63:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(4), .DATA_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rf_ready  (rf_ready),
        .we_onehot (we_onehot),
        .we_data   (we_data),
        .pending   (pending),
`ifdef WB_FWD_EN
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
`endif
        .empty     (empty),
        .full      (full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [63:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rf_ready = 1'b1;
`ifdef WB_FWD_EN
        fwd_addr = 5'd0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_we",      {32'd0, we_onehot}, 64'd0);
        check("rst_wdata",   we_data, 64'd0);
        check("rst_pending", {32'd0, pending}, 64'd0);
        check("rst_empty",   {63'd0, empty}, 64'd1);
        check("rst_full",    {63'd0, full}, 64'd0);
        check("rst_ready",   {63'd0, wr_ready}, 64'd1);

        // single write X5, two-cycle latency
        push(5'd5, 64'h1234);
        check("x5_pend_t1",  {32'd0, pending}, 64'h20);
        check("x5_we_t1",    {32'd0, we_onehot}, 64'd0);
        check("x5_empty_t1", {63'd0, empty}, 64'd0);
        tick();
        check("x5_we_t2",    {32'd0, we_onehot}, 64'h20);
        check("x5_data_t2",  we_data, 64'h1234);
        check("x5_pend_t2",  {32'd0, pending}, 64'h20);
        tick();
        check("x5_we_t3",    {32'd0, we_onehot}, 64'd0);
        check("x5_pend_t3",  {32'd0, pending}, 64'd0);
        check("x5_hold",     we_data, 64'h1234);

        // write to XZR is swallowed
        wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF;
        #1;
        check("xzr_ready", {63'd0, wr_ready}, 64'd1);
        tick();
        wr_valid = 1'b0;
        check("xzr_empty", {63'd0, empty}, 64'd1);
        check("xzr_pend",  {32'd0, pending}, 64'd0);
        tick();
        check("xzr_we",    {32'd0, we_onehot}, 64'd0);

        // fill with rf_ready low, then drain in order
        rf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 64'(16 + i));
        check("fill_full",  {63'd0, full}, 64'd1);
        check("fill_ready", {63'd0, wr_ready}, 64'd0);
        check("fill_pend",  {32'd0, pending}, 64'h1E);
        check("fill_we",    {32'd0, we_onehot}, 64'd0);
        push(5'd6, 64'h66);
        check("full_nopush", {32'd0, pending}, 64'h1E);
        rf_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("drain_we%0d", i),   {32'd0, we_onehot}, 64'd1 << i);
            check($sformatf("drain_data%0d", i), we_data, 64'(16 + i));
        end
        tick();
        check("drain_idle", {32'd0, we_onehot}, 64'd0);
        check("drain_pend", {32'd0, pending}, 64'd0);
        check("drain_empty", {63'd0, empty}, 64'd1);

        // same register twice, back to back
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 64'hA;
        tick();
        wr_data = 64'hB;
        tick();
        wr_valid = 1'b0;
        check("x7a_we",   {32'd0, we_onehot}, 64'h80);
        check("x7a_data", we_data, 64'hA);
        check("x7a_pend", {32'd0, pending}, 64'h80);
        tick();
        check("x7b_we",   {32'd0, we_onehot}, 64'h80);
        check("x7b_data", we_data, 64'hB);
        check("x7b_pend", {32'd0, pending}, 64'h80);
        tick();
        check("x7_done_we",   {32'd0, we_onehot}, 64'd0);
        check("x7_done_pend", {32'd0, pending}, 64'd0);

        // push and pop together at count DEPTH-1
        rf_ready = 1'b0;
        push(5'd10, 64'hA0);
        push(5'd11, 64'hB0);
        push(5'd12, 64'hC0);
        rf_ready = 1'b1;
        push(5'd13, 64'hD0);
        rf_ready = 1'b0;
        check("pp_we",   {32'd0, we_onehot}, 64'h400);
        check("pp_data", we_data, 64'hA0);
        check("pp_full", {63'd0, full}, 64'd0);
        check("pp_pend", {32'd0, pending}, 64'h3C00);
        tick();
        check("pp_pend2", {32'd0, pending}, 64'h3800);
        rf_ready = 1'b1;
        for (int i = 11; i <= 13; i++) begin
            tick();
            check($sformatf("pp_drain%0d", i), {32'd0, we_onehot}, 64'd1 << i);
        end
        tick();
        check("pp_empty", {63'd0, empty}, 64'd1);

        // reset with entries queued and one mid-drain
        rf_ready = 1'b0;
        push(5'd2, 64'h22);
        push(5'd3, 64'h33);
        push(5'd4, 64'h44);
        check("mr_pend", {32'd0, pending}, 64'h1C);
        rf_ready = 1'b1;
        tick();
        check("mr_we_pre", {32'd0, we_onehot}, 64'h4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mr_we",    {32'd0, we_onehot}, 64'd0);
        check("mr_pend0", {32'd0, pending}, 64'd0);
        check("mr_empty", {63'd0, empty}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr_quiet%0d", i), {32'd0, we_onehot}, 64'd0);
        end

`ifdef WB_FWD_EN
        rf_ready = 1'b0;
        push(5'd9, 64'h1);
        push(5'd9, 64'h2);
        fwd_addr = 5'd9;
        #1;
        check("fwd_hit",  {63'd0, fwd_hit}, 64'd1);
        check("fwd_data", fwd_data, 64'h2);
        fwd_addr = 5'd31;
        #1;
        check("fwd_xzr",  {63'd0, fwd_hit}, 64'd0);
        fwd_addr = 5'd8;
        #1;
        check("fwd_miss", {63'd0, fwd_hit}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
